// File: rtl/intr_controller_pkg.sv
// Shared definitions for the interrupt controller.
//   VectorAddrDefault : default ISR entry address
//   AckCntWidth       : width of the acknowledge-wait counter
//   intr_state_e      : controller FSM state encoding
package intr_controller_pkg;

   localparam logic [31:0] VectorAddrDefault = 32'h0000_03FC;
   localparam int unsigned AckCntWidth       = 4;

   typedef enum logic [2:0] {
      StIdle,
      StPend,
      StFlush,
      StAck,
      StIsr,
      StRet
   } intr_state_e;

endpackage

// File: rtl/intr_controller_if.sv
// Signal bundle between the interrupt controller, the CPU pipeline and the IO memory.
//   master : controller side (drives acknowledge, PC redirect, flush, status)
//   slave  : CPU / IO side (drives request, enable, pipeline status, resume PC, reti)
interface intr_controller_if;

   logic        intr;
   logic        intr_ack;
   logic        int_en;
   logic        pipe_stall;
   logic        id_branch;
   logic [31:0] pc_cur;
   logic        reti;
   logic        pc_force;
   logic [31:0] pc_target;
   logic        pipe_flush;
   logic [31:0] epc;
   logic        in_isr;
   logic        ack_timeout;

   modport master (
      input  intr, int_en, pipe_stall, id_branch, pc_cur, reti,
      output intr_ack, pc_force, pc_target, pipe_flush, epc, in_isr, ack_timeout
   );

   modport slave (
      output intr, int_en, pipe_stall, id_branch, pc_cur, reti,
      input  intr_ack, pc_force, pc_target, pipe_flush, epc, in_isr, ack_timeout
   );

endinterface

// File: rtl/intr_controller.sv
// Single-level interrupt controller for an in-order CPU pipeline.
// Waits for a safe point (no stall, no branch in ID), saves the resume PC, redirects
// fetch to the ISR vector, handshakes the request with the IO memory, and on reti
// redirects fetch back to the saved PC.
//   clk         : clock, all state changes on the rising edge
//   rst         : asynchronous active-high reset
//   bus.intr*   : level request / acknowledge with the IO memory
//   bus.int_en, pipe_stall, id_branch, pc_cur, reti : CPU status inputs
//   bus.pc_force, pc_target, pipe_flush : PC redirect and pipeline squash
//   bus.epc, in_isr, ack_timeout        : saved PC and status flags
module intr_controller
   import intr_controller_pkg::*;
#(
   parameter logic [31:0] VECTOR_ADDR = VectorAddrDefault,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input logic               clk,
   input logic               rst,
   intr_controller_if.master bus
);

   localparam logic [AckCntWidth:0] AckLimit = (AckCntWidth + 1)'(ACK_TIMEOUT);

   intr_state_e            state_q, state_d;
   logic [31:0]            epc_q, epc_d;
   logic [AckCntWidth-1:0] cnt_q, cnt_d;
   logic                   timeout_q, timeout_d;
   logic [AckCntWidth:0]   cnt_inc;

   // One extra bit so the limit compare cannot wrap.
   assign cnt_inc = {1'b0, cnt_q} + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         epc_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         epc_q     <= epc_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      epc_d     = epc_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (bus.intr && bus.int_en) state_d = StPend;
         end
         StPend: begin
            // Spurious request: drop back without touching epc.
            if (!bus.intr) begin
               state_d = StIdle;
            end else if (!bus.pipe_stall && !bus.id_branch) begin
               epc_d   = bus.pc_cur;
               state_d = StFlush;
            end
         end
         StFlush: begin
            cnt_d   = '0;
            state_d = StAck;
         end
         StAck: begin
            if (!bus.intr) begin
               cnt_d   = '0;
               state_d = StIsr;
            end else if (cnt_inc >= AckLimit) begin
               // Give up on the handshake but still run the ISR.
               cnt_d     = '0;
               timeout_d = 1'b1;
               state_d   = StIsr;
            end else begin
               cnt_d = cnt_inc[AckCntWidth-1:0];
            end
         end
         StIsr: begin
            if (bus.reti) state_d = StRet;
         end
         StRet: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      bus.intr_ack    = 1'b0;
      bus.pc_force    = 1'b0;
      bus.pipe_flush  = 1'b0;
      bus.pc_target   = VECTOR_ADDR;
      bus.in_isr      = 1'b0;
      bus.epc         = epc_q;
      bus.ack_timeout = timeout_q;
      unique case (state_q)
         StFlush: begin
            bus.pc_force   = 1'b1;
            bus.pipe_flush = 1'b1;
         end
         StAck: begin
            bus.intr_ack = 1'b1;
         end
         StIsr: begin
            bus.in_isr = 1'b1;
         end
         StRet: begin
            bus.pc_force   = 1'b1;
            bus.pipe_flush = 1'b1;
            bus.pc_target  = epc_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: a flag-based reference model tracks what the
// outputs must be and is compared on every falling edge; literal checks pin key points.
module tb_intr_controller;

   localparam logic [31:0] Vec = 32'h0000_03FC;
   localparam int          Tmo = 15;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   intr_controller_if u_if ();

   intr_controller #(
      .VECTOR_ADDR (Vec),
      .ACK_TIMEOUT (Tmo)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one flag per phase of the interrupt sequence.
   bit          m_pend  = 1'b0;
   bit          m_flush = 1'b0;
   bit          m_ack   = 1'b0;
   bit          m_isr   = 1'b0;
   bit          m_ret   = 1'b0;
   bit          m_to    = 1'b0;
   int          m_wait  = 0;
   logic [31:0] m_epc   = 32'h0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = 0; m_flush = 0; m_ack = 0; m_isr = 0; m_ret = 0; m_to = 0;
         m_wait = 0; m_epc = 32'h0;
      end else if (m_flush) begin
         m_flush = 0; m_ack = 1; m_wait = 0;
      end else if (m_ack) begin
         m_wait = m_wait + 1;
         if (!u_if.intr) begin
            m_ack = 0; m_isr = 1;
         end else if (m_wait == Tmo) begin
            m_ack = 0; m_isr = 1; m_to = 1;
         end
      end else if (m_isr) begin
         if (u_if.reti) begin
            m_isr = 0; m_ret = 1;
         end
      end else if (m_ret) begin
         m_ret = 0;
      end else if (m_pend) begin
         if (!u_if.intr) begin
            m_pend = 0;
         end else if (!u_if.pipe_stall && !u_if.id_branch) begin
            m_pend = 0; m_flush = 1; m_epc = u_if.pc_cur;
         end
      end else if (u_if.intr && u_if.int_en) begin
         m_pend = 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_intr_ack",    32'(u_if.intr_ack),    32'(m_ack));
      chk("m_pc_force",    32'(u_if.pc_force),    32'(m_flush | m_ret));
      chk("m_pipe_flush",  32'(u_if.pipe_flush),  32'(m_flush | m_ret));
      chk("m_pc_target",   u_if.pc_target,        m_ret ? m_epc : Vec);
      chk("m_in_isr",      32'(u_if.in_isr),      32'(m_isr));
      chk("m_epc",         u_if.epc,              m_epc);
      chk("m_ack_timeout", 32'(u_if.ack_timeout), 32'(m_to));
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int n_ack;
      rst = 1'b1;
      u_if.intr = 0; u_if.int_en = 0; u_if.pipe_stall = 0; u_if.id_branch = 0;
      u_if.pc_cur = 32'h0; u_if.reti = 0;
      tick(2);
      chk("rst_intr_ack", 32'(u_if.intr_ack), 0);
      chk("rst_epc", u_if.epc, 0);
      chk("rst_pc_target", u_if.pc_target, Vec);
      rst = 1'b0;
      tick(1);

      // Basic handshake: intr high for 4 edges.
      u_if.int_en = 1; u_if.pc_cur = 32'h40; u_if.intr = 1;
      tick(2);
      chk("basic_pc_force", 32'(u_if.pc_force), 1);
      chk("basic_pc_target", u_if.pc_target, 32'h3FC);
      chk("basic_pipe_flush", 32'(u_if.pipe_flush), 1);
      chk("basic_epc", u_if.epc, 32'h40);
      tick(1);
      chk("basic_ack1", 32'(u_if.intr_ack), 1);
      chk("basic_force_off", 32'(u_if.pc_force), 0);
      tick(1);
      chk("basic_ack2", 32'(u_if.intr_ack), 1);
      u_if.intr = 0;
      tick(1);
      chk("basic_in_isr", 32'(u_if.in_isr), 1);
      chk("basic_ack_off", 32'(u_if.intr_ack), 0);

      // Return from interrupt, then reti while idle.
      u_if.reti = 1;
      tick(1);
      chk("ret_pc_force", 32'(u_if.pc_force), 1);
      chk("ret_pc_target", u_if.pc_target, 32'h40);
      chk("ret_pipe_flush", 32'(u_if.pipe_flush), 1);
      u_if.reti = 0;
      tick(1);
      chk("ret_idle_isr", 32'(u_if.in_isr), 0);
      chk("ret_idle_force", 32'(u_if.pc_force), 0);
      u_if.reti = 1;
      tick(2);
      chk("reti_idle_force", 32'(u_if.pc_force), 0);
      chk("reti_idle_isr", 32'(u_if.in_isr), 0);
      u_if.reti = 0;

      // Deferred: 3 edges of branch, 2 of stall, then release.
      u_if.pc_cur = 32'h100; u_if.intr = 1;
      tick(1);
      u_if.id_branch = 1;
      tick(3);
      chk("defer_branch_force", 32'(u_if.pc_force), 0);
      u_if.id_branch = 0; u_if.pipe_stall = 1; u_if.pc_cur = 32'h110;
      tick(2);
      chk("defer_stall_force", 32'(u_if.pc_force), 0);
      chk("defer_epc_held", u_if.epc, 32'h40);
      u_if.pipe_stall = 0; u_if.pc_cur = 32'h120;
      tick(1);
      chk("defer_release_force", 32'(u_if.pc_force), 1);
      chk("defer_epc", u_if.epc, 32'h120);
      u_if.intr = 0;
      tick(2);
      chk("defer_in_isr", 32'(u_if.in_isr), 1);
      u_if.reti = 1;
      tick(1);
      chk("defer_ret_target", u_if.pc_target, 32'h120);
      u_if.reti = 0;
      tick(1);

      // Timeout: intr stuck high.
      u_if.pc_cur = 32'h200; u_if.intr = 1;
      tick(3);
      n_ack = 0;
      for (int i = 0; i < 20; i++) begin
         if (u_if.intr_ack) n_ack++;
         tick(1);
      end
      chk("tmo_ack_cycles", 32'(n_ack), 15);
      chk("tmo_flag", 32'(u_if.ack_timeout), 1);
      chk("tmo_in_isr", 32'(u_if.in_isr), 1);
      chk("tmo_epc", u_if.epc, 32'h200);
      u_if.intr = 0; u_if.reti = 1;
      tick(1);
      u_if.reti = 0;
      tick(1);
      chk("tmo_flag_sticky", 32'(u_if.ack_timeout), 1);
      chk("tmo_idle_isr", 32'(u_if.in_isr), 0);

      // Masked request.
      u_if.int_en = 0; u_if.intr = 1;
      tick(4);
      chk("mask_force", 32'(u_if.pc_force), 0);
      chk("mask_ack", 32'(u_if.intr_ack), 0);
      u_if.intr = 0;

      // Spurious request dropped while pending.
      u_if.int_en = 1; u_if.pc_cur = 32'h300; u_if.intr = 1;
      tick(1);
      u_if.intr = 0;
      tick(2);
      chk("spur_epc", u_if.epc, 32'h200);
      chk("spur_force", 32'(u_if.pc_force), 0);
      chk("spur_flag_sticky", 32'(u_if.ack_timeout), 1);

      // Asynchronous reset between edges during ACK.
      u_if.pc_cur = 32'h400; u_if.intr = 1;
      tick(3);
      chk("areset_pre_ack", 32'(u_if.intr_ack), 1);
      #2 rst = 1'b1;
      #1;
      chk("areset_ack", 32'(u_if.intr_ack), 0);
      chk("areset_flag", 32'(u_if.ack_timeout), 0);
      chk("areset_epc", u_if.epc, 0);
      chk("areset_isr", 32'(u_if.in_isr), 0);
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("post_rst_pend", 32'(u_if.pc_force), 0);
      tick(1);
      chk("post_rst_force", 32'(u_if.pc_force), 1);
      chk("post_rst_epc", u_if.epc, 32'h400);
      u_if.intr = 0;
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/intr_controller.md
INTR_CONTROLLER -- requirements
Module: intr_controller

Interface
REQ-001 The block SHALL have one parameter VECTOR_ADDR, default 32'h0000_03FC, which is the ISR entry address.
REQ-002 The block SHALL have one parameter ACK_TIMEOUT, default 15, which is the maximum number of cycles intr_ack is held waiting for intr to drop.
REQ-003 Port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, width 1: reset, asynchronous and active-high.
REQ-005 Port intr, input, width 1: level interrupt request from the IO memory.
REQ-006 Port intr_ack, output, width 1: interrupt acknowledge to the IO memory.
REQ-007 Port int_en, input, width 1: global interrupt enable from the CPU status register.
REQ-008 Port pipe_stall, input, width 1: pipeline is stalled this cycle.
REQ-009 Port id_branch, input, width 1: the ID-stage instruction is a branch or jump.
REQ-010 Port pc_cur, input, width 32: resume PC, the oldest unretired instruction.
REQ-011 Port reti, input, width 1: return-from-interrupt decoded in ID.
REQ-012 Port pc_force, output, width 1: select pc_target as the next PC.
REQ-013 Port pc_target, output, width 32: forced PC value.
REQ-014 Port pipe_flush, output, width 1: squash the IF/ID/EX stages.
REQ-015 Port epc, output, width 32: saved exception PC.
REQ-016 Port in_isr, output, width 1: the ISR is executing.
REQ-017 Port ack_timeout, output, width 1: sticky error flag, set when the acknowledge handshake times out.

Function
REQ-018 The FSM SHALL have exactly six states: IDLE, PEND, FLUSH, ACK, ISR and RET, and all outputs SHALL be Moore-decoded from registered state.
REQ-019 In IDLE, intr=1 and int_en=1 at a clock edge SHALL move the FSM to PEND; otherwise it SHALL stay in IDLE.
REQ-020 In PEND with intr=0, the FSM SHALL return to IDLE; epc SHALL be unchanged and no outputs SHALL be asserted.
REQ-021 In PEND with intr=1, pipe_stall=0 and id_branch=0, the block SHALL load epc from pc_cur and move to FLUSH; otherwise it SHALL stay in PEND.
REQ-022 In FLUSH, pc_force=1, pipe_flush=1 and pc_target=VECTOR_ADDR SHALL be driven for exactly one cycle, after which the FSM SHALL move to ACK.
REQ-023 In ACK, intr_ack=1 SHALL be driven and a 4-bit counter SHALL increment each cycle.
REQ-024 In ACK, intr=0 SHALL move the FSM to ISR and clear the counter.
REQ-025 In ACK, if the counter reaches ACK_TIMEOUT, the block SHALL set ack_timeout=1 and move to ISR.
REQ-026 In ISR, in_isr=1 SHALL be driven and intr SHALL be ignored (no nesting).
REQ-027 In ISR, reti=1 SHALL move the FSM to RET.
REQ-028 In RET, pc_force=1, pipe_flush=1 and pc_target=epc SHALL be driven for one cycle, after which the FSM SHALL move to IDLE.
REQ-029 reti in any state other than ISR SHALL be ignored.
REQ-030 intr that is still high after RET SHALL be recognised no earlier than the first IDLE cycle, and int_en SHALL be re-sampled at that point.
REQ-031 Minimum latency SHALL be 2 edges from intr=1 in IDLE to pc_force=1, given no stall or branch.
REQ-032 pc_target SHALL be VECTOR_ADDR in all states except RET.
REQ-033 pc_force and pipe_flush SHALL be 0 in all states except FLUSH and RET.
REQ-034 ack_timeout SHALL remain set until reset.

Reset
REQ-035 rst=1 SHALL immediately force the state to IDLE, set intr_ack, pc_force, pipe_flush, in_isr and ack_timeout to 0, and clear epc and the counter to 0, including when reset asserts mid-handshake or inside the ISR.
REQ-036 After rst deasserts, the first state change SHALL occur no earlier than the next rising clk edge.

Structure
REQ-037 The state encoding and the default VECTOR_ADDR SHALL live in the shared CPU definitions package/include.
REQ-038 The block SHALL contain no sub-modules; the ACK counter SHALL be inline.

Verification
REQ-039 The bench SHALL cover the basic handshake: int_en=1, pc_cur=0x40, intr pulsed high for 4 cycles -> pc_force=1 with pc_target=0x3FC on edge 2, epc=0x40, intr_ack high until intr falls, then in_isr=1.
REQ-040 The bench SHALL cover the deferred interrupt: intr=1 with id_branch=1 for 3 cycles and pipe_stall=1 for 2 more -> the FSM stays in PEND for 5 cycles, then FLUSH, with epc equal to pc_cur on the release cycle.
REQ-041 The bench SHALL cover the return: reti=1 while in ISR with epc=0x40 -> one cycle of pc_force=1, pc_target=0x40, pipe_flush=1, then IDLE with in_isr=0; reti in IDLE -> no response.
REQ-042 The bench SHALL cover the timeout: intr held high forever -> intr_ack drops after 15 cycles, ack_timeout=1, the FSM enters ISR, and the flag persists until rst.
REQ-043 The bench SHALL cover masking and spurious requests: int_en=0 with intr=1 -> no outputs asserted; intr high for 1 cycle then low while in PEND -> return to IDLE with epc unchanged.
REQ-044 The bench SHALL cover asynchronous reset: rst asserted between clock edges during ACK -> intr_ack=0 and state IDLE before the next edge.
